vram_frame_writer: RTL and testbench

- Write-side engine for the 1-bit-per-pixel VRAM frame BRAMs; the VGA scan path is the only reader.
- Accepts a packed pixel stream (16 pixels per word, valid/ready) or a fill command.
- Drives the BRAM port A write interface: enable, write-enable, address, data bit.
- Gates all writes with a blanking qualifier so frame updates do not tear on screen.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_pixel_serializer.sv | 39 +++
 rtl/vram_frame_writer.sv | 130 +++++++++++++
 tb/tb_vram_frame_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM frame write path.
// Imported by the frame writer FSM and its pixel serializer.
package vram_pkg;

  localparam int VRAM_ADDR_W          = 14;
  localparam int FRAME_PIXELS_DEFAULT = 16384;
  localparam int VRAM_WORD_W          = 16;

  localparam logic [1:0] WE_ALL  = 2'b11;
  localparam logic [1:0] WE_NONE = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FILL,
    DONE
  } vram_state_t;

endpackage

// File: rtl/vram_pixel_serializer.sv
// Serializes one packed stream word into pixels, LSB first.
// Load takes priority so a word can be reloaded on its last bit.
module vram_pixel_serializer
  import vram_pkg::*;
#(
  parameter int WORD_W = VRAM_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              advance,
  output logic              pixel,
  output logic              last
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else if (advance) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign pixel = shreg[0];
  assign last  = (bit_cnt == LAST_BIT);

endmodule

// File: rtl/vram_frame_writer.sv
// Write-side engine for the 1bpp VRAM frame BRAMs.
// Streams packed words or fills a frame, gated by write_allow.
module vram_frame_writer
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int WORD_W       = VRAM_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fill_mode,
  input  logic              fill_val,
  input  logic              write_allow,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_din,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(FRAME_PIXELS - 1);

  vram_state_t       state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              fill_q;
  logic              pixel;
  logic              last;
  logic              wr;
  logic              at_end;
  logic              hs;
  logic              advance;

  vram_pixel_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (hs),
    .load_data (s_data),
    .advance   (advance),
    .pixel     (pixel),
    .last      (last)
  );

  // A word may be refilled on its final bit, except for the frame's last word.
  always_comb begin
    at_end  = (addr_cnt == LAST_ADDR);
    wr      = 1'b0;
    s_ready = 1'b0;
    unique case (1'b1)
      (state == LOAD):  s_ready = 1'b1;
      (state == SHIFT): begin
        wr      = write_allow;
        s_ready = last && write_allow && !at_end;
      end
      (state == FILL):  wr = write_allow;
      default: ;
    endcase
    hs      = s_valid && s_ready;
    advance = wr && (state == SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_cnt <= '0;
      fill_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= WE_NONE;
      mem_addr <= '0;
      mem_din  <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_en <= wr;
      mem_we <= wr ? WE_ALL : WE_NONE;
      if (wr) begin
        mem_addr <= addr_cnt;
        mem_din  <= (state == FILL) ? fill_q : pixel;
        if (!at_end) begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= fill_mode ? FILL : LOAD;
            fill_q   <= fill_val;
            addr_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (wr) begin
            if (at_end) begin
              state <= DONE;
            end else if (last && !hs) begin
              state <= LOAD;
            end
          end
        end
        FILL: begin
          if (wr && at_end) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_frame_writer.sv
// Randomized bench for vram_frame_writer with a frame-level model.
// Model tracks pixel order per command; tasks pin literal timings.
module tb_vram_frame_writer;

  localparam int FP = 16384;
  localparam int AW = 14;
  localparam logic [AW-1:0] LAST = AW'(FP - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          fill_mode = 1'b0;
  logic          fill_val = 1'b0;
  logic          write_allow = 1'b0;
  logic          s_valid = 1'b0;
  logic [15:0]   s_data = '0;
  logic          s_ready;
  logic          mem_en;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_din;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_frame_writer #(
    .ADDR_W       (AW),
    .FRAME_PIXELS (FP),
    .WORD_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fill_mode   (fill_mode),
    .fill_val    (fill_val),
    .write_allow (write_allow),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .busy        (busy),
    .done        (done)
  );

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name, input int a, input int b);
    tests++;
    fails++;
    $display("FAIL %s: got %0d required below %0d at %0t", name, a, b, $time);
  endfunction

  // Frame-level model: pixel k of a command goes to address k,
  // carrying fill_val or bit k%16 of the (k/16)-th accepted word.
  bit          m_active, m_fill, m_fv, m_pend_done;
  bit          p_start, p_fm, p_fv, p_wa;
  int          m_nwr;
  logic [15:0] m_words[$];
  logic [15:0] m_w;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs",
          {s_ready, mem_en, mem_we, mem_addr, mem_din, busy, done}, 0);
      m_active = 0; m_pend_done = 0; m_nwr = 0;
      m_words.delete();
      p_start = 0; p_wa = 0;
    end else begin
      if (p_start && !m_active) begin
        m_active = 1; m_fill = p_fm; m_fv = p_fv;
        m_nwr = 0; m_words.delete();
      end
      if (m_pend_done) begin
        chk("done_pulse", done, 1);
        m_active = 0; m_pend_done = 0;
      end else if (done) begin
        chk("spurious_done", done, 0);
      end
      chk("busy", busy, m_active);
      if (mem_en) begin
        chk("we_value", mem_we, 3);
        chk("write_gated", p_wa, 1);
        chk("write_in_cmd", m_active, 1);
        chk("write_addr", mem_addr, m_nwr);
        if (m_fill) begin
          chk("fill_din", mem_din, m_fv);
        end else if ((m_nwr >> 4) < m_words.size()) begin
          m_w = m_words[m_nwr >> 4];
          chk("stream_din", mem_din, m_w[m_nwr & 15]);
        end else begin
          fail_now("write_without_data", m_nwr >> 4, m_words.size());
        end
        if (mem_addr == LAST) m_pend_done = 1;
        m_nwr++;
      end else begin
        chk("we_idle", mem_we, 0);
      end
      if (s_valid && s_ready) m_words.push_back(s_data);
      p_start = start; p_fm = fill_mode; p_fv = fill_val; p_wa = write_allow;
    end
  end

  int       r_wr, r_first_wr, r_last_wr, r_done, r_busy1;
  int       r_hs, r_first_hs, r_hs_bad, r_stall_en, r_resume_addr, r_first_addr;
  logic [7:0] r_first8;
  bit       r_aborted;

  function automatic logic wa_val(input int wam, input int cyc);
    if (wam == 0) return 1'b1;
    if (wam == 1) return (cyc % 8) < 3;
    return $urandom_range(0, 99) < 85;
  endfunction

  task automatic run_cmd(input bit fm, input bit fv, input int wam,
                         input int svm, input bit rnd, input int abort_at);
    int cyc = 0, widx = 0, gst = 0, gap = 0, prev_hs = -1;
    bit fin = 0, hs, want_resume = 0;
    logic [15:0] cur;
    r_wr = 0; r_first_wr = -1; r_last_wr = -1; r_done = -1; r_busy1 = -1;
    r_hs = 0; r_first_hs = -1; r_hs_bad = 0; r_stall_en = 0;
    r_resume_addr = -1; r_first_addr = -1; r_first8 = '0; r_aborted = 0;
    cur = rnd ? 16'($urandom) : 16'hA5A5;
    @(posedge clk); #1;
    start = 1; fill_mode = fm; fill_val = fv;
    write_allow = wa_val(wam, 0);
    s_valid = !fm; s_data = cur;
    while (!fin) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) begin
        r_hs++;
        if (prev_hs < 0) r_first_hs = cyc;
        else if (cyc - prev_hs != 16) r_hs_bad++;
        prev_hs = cyc;
      end
      if (busy && r_busy1 < 0) r_busy1 = cyc;
      if (gst == 2) begin
        r_stall_en += int'(mem_en);
        gap--;
        if (gap == 0) begin gst = 3; want_resume = 1; end
      end else if (mem_en) begin
        if (r_wr == 0) begin r_first_wr = cyc; r_first_addr = int'(mem_addr); end
        r_last_wr = cyc;
        if (r_wr < 8) r_first8[r_wr] = mem_din;
        if (want_resume) begin r_resume_addr = int'(mem_addr); want_resume = 0; end
        if (gst == 1 && mem_addr == AW'(47)) begin gst = 2; gap = 20; end
        r_wr++;
      end
      if (done) begin
        r_done = cyc; fin = 1;
      end else if (abort_at >= 0 && mem_en && mem_addr == AW'(abort_at)) begin
        #2 reset = 0;
        #1 chk("async_reset_outputs",
               {s_ready, mem_en, mem_we, mem_addr, mem_din, busy, done}, 0);
        r_aborted = 1; fin = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1;
      end else if (cyc > 60000) begin
        fail_now("cmd_timeout", cyc, 60000);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
        start = 0;
        if (cyc == 300) begin start = 1; fill_mode = !fm; fill_val = !fv; end
        if (hs) begin widx++; cur = rnd ? 16'($urandom) : 16'hA5A5; end
        if (svm == 1 && gst == 0 && widx == 3) gst = 1;
        write_allow = wa_val(wam, cyc);
        if (fm || widx >= 1024 || gst == 1 || gst == 2) s_valid = 0;
        else s_valid = (svm == 0) ? 1'b1 : ($urandom_range(0, 99) < 80);
        s_data = s_valid ? cur : 16'($urandom);
      end
    end
    @(posedge clk); #1;
    start = 0; fill_mode = 0; fill_val = 0; s_valid = 0; write_allow = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;
    idle(2);

    run_cmd(0, 0, 0, 0, 0, -1);
    chk("t1_writes", r_wr, FP);
    chk("t1_contiguous", r_last_wr - r_first_wr, FP - 1);
    chk("t1_done_after_last", r_done - r_last_wr, 1);
    chk("t1_handshakes", r_hs, 1024);
    chk("t1_ready_every16", r_hs_bad, 0);
    chk("t1_first_latency", r_first_wr - r_first_hs, 2);
    chk("t1_first8_pixels", r_first8, 8'hA5);
    idle(3);
    chk("t1_busy_low", busy, 0);

    run_cmd(1, 0, 1, 0, 0, 5000);
    chk("t2_aborted", r_aborted, 1);
    chk("t2_writes_to_abort", r_wr, 5001);
    idle(4);
    chk("t2_no_done_after_abort", done, 0);

    run_cmd(1, 1, 0, 0, 0, -1);
    chk("t3_writes", r_wr, FP);
    chk("t3_restart_addr", r_first_addr, 0);
    chk("t3_contiguous", r_last_wr - r_first_wr, FP - 1);
    chk("t3_done_latency", r_done - r_busy1, FP + 1);
    idle(3);

    run_cmd(0, 0, 2, 1, 1, -1);
    chk("t4_writes", r_wr, FP);
    chk("t4_stall_no_write", r_stall_en, 0);
    chk("t4_resume_addr", r_resume_addr, 48);
    chk("t4_done_seen", r_done > 0, 1);
    idle(3);
    chk("t4_busy_low", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
